// File: rtl/fir_frame_sequencer.sv
// rtl/fir_frame_sequencer.sv - frame sequencer for a clk_en-gated FIR core
// Purpose: pulls N samples from an input valid/ready stream, feeds them to the
//   FIR core one advance at a time at a programmable pace, flushes the core with
//   LATENCY zeros, drops the core's first LATENCY outputs and emits exactly N
//   outputs on an output valid/ready stream.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, frame_len, busy, done   frame control / status
//   s_data, s_valid, s_ready       input sample stream
//   f_clk_en, f_xin, f_yout        FIR core enable, input, output
//   m_data, m_valid, m_ready       output sample stream
module fir_frame_sequencer #(
   parameter int DW       = 16,
   parameter int LEN_W    = 12,
   parameter int RATE_DIV = 4,
   parameter int LATENCY  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   output logic             busy,
   output logic             done,
   input  logic [DW-1:0]    s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             f_clk_en,
   output logic [DW-1:0]    f_xin,
   input  logic [DW-1:0]    f_yout,
   output logic [DW-1:0]    m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   localparam int CW    = LEN_W + 1;
   localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [CW-1:0]    LAT_C   = CW'(LATENCY);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RATE_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     len, in_cnt, out_cnt, fl_cnt, cap_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic              cap_pend;
   logic              tick, slot_free, start_ok, s_fire, fl_fire, out_fire;

   assign tick      = (div_cnt == '0);
   // Only one core advance may be in flight: strobe -> capture -> output handshake.
   assign slot_free = !m_valid && !f_clk_en && !cap_pend;
   assign start_ok  = (state == S_IDLE) && start && (frame_len != '0);
   assign s_fire    = s_valid && s_ready;
   assign out_fire  = m_valid && m_ready;
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      done      = 1'b0;
      fl_fire   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_ok) state_nxt = S_RUN;
         end
         S_RUN: begin
            s_ready = tick && slot_free;
            if (s_valid && tick && slot_free && (in_cnt + CW'(1) == len))
               state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            fl_fire = tick && slot_free && (fl_cnt != LAT_C);
            // The last output is always captured in FLUSH, so its handshake ends the frame.
            if (out_fire && (out_cnt == len)) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len      <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         fl_cnt   <= '0;
         cap_cnt  <= '0;
         div_cnt  <= '0;
         cap_pend <= 1'b0;
         f_clk_en <= 1'b0;
         f_xin    <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
      end else begin
         f_clk_en <= 1'b0;
         cap_pend <= f_clk_en;

         if ((state == S_RUN) || (state == S_FLUSH))
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
         else
            div_cnt <= '0;

         if (start_ok) begin
            len     <= {1'b0, frame_len};
            in_cnt  <= '0;
            out_cnt <= '0;
            fl_cnt  <= '0;
            cap_cnt <= '0;
         end

         if (s_fire) begin
            f_xin    <= s_data;
            f_clk_en <= 1'b1;
            in_cnt   <= in_cnt + CW'(1);
         end

         if (fl_fire) begin
            f_xin    <= '0;
            f_clk_en <= 1'b1;
            fl_cnt   <= fl_cnt + CW'(1);
         end

         if (out_fire) m_valid <= 1'b0;

         // f_yout settles one edge after the strobe; the first LATENCY results
         // are pipeline fill and are dropped.
         if (cap_pend) begin
            cap_cnt <= cap_cnt + CW'(1);
            if (cap_cnt >= LAT_C) begin
               m_data  <= f_yout;
               m_valid <= 1'b1;
               out_cnt <= out_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// tb/tb_fir_frame_sequencer.sv - directed self-checking bench for fir_frame_sequencer
module tb_fir_frame_sequencer;

   localparam int LAT = 2;

   logic        clk, rst, start, busy, done;
   logic [11:0] frame_len;
   logic [15:0] s_data, f_xin, f_yout, m_data;
   logic        s_valid, s_ready, f_clk_en, m_valid, m_ready;

   fir_frame_sequencer #(.DW(16), .LEN_W(12), .RATE_DIV(4), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .busy(busy), .done(done),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .f_clk_en(f_clk_en), .f_xin(f_xin), .f_yout(f_yout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_strb   = 0;
   int n_done   = 0;
   bit src_en   = 0;
   logic [15:0] src_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] out_q[$];
   logic [15:0] strb_q[$];
   logic [15:0] pipe [0:LAT];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Stub core: output after strobe k is the input given at strobe k-LAT.
   initial for (int i = 0; i <= LAT; i++) pipe[i] = '0;
   always @(posedge clk) begin
      if (f_clk_en) begin
         pipe[0] <= f_xin;
         for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign f_yout = pipe[LAT];

   // Source: handshake seen at negedge, consumed at next posedge.
   initial begin
      s_valid = 0;
      s_data  = 0;
      forever begin
         @(negedge clk);
         if (s_valid && s_ready) void'(src_q.pop_front());
         @(posedge clk);
         #1;
         if (src_en && src_q.size() > 0) begin
            s_valid = 1;
            s_data  = src_q[0];
         end else begin
            s_valid = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (f_clk_en) begin
            n_strb++;
            strb_q.push_back(f_xin);
         end
         if (m_valid && m_ready) out_q.push_back(m_data);
         if (done) n_done++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      out_q.delete();
      strb_q.delete();
      exp_q.delete();
      n_strb = 0;
   endtask

   task automatic push(input logic [15:0] d);
      src_q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic start_frame(input logic [11:0] len);
      frame_len = len;
      start = 1;
      step(1);
      start = 0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (done !== 1'b1 && c < budget);
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_busy_with_done"}, busy, 1);
      @(negedge clk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_width"}, done, 0);
   endtask

   task automatic chk_out(input string tag);
      chk({tag, "_out_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_out%0d", tag, i), out_q[i], exp_q[i]);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_f_clk_en"}, f_clk_en, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_f_xin"}, f_xin, 0);
      chk({tag, "_m_data"}, m_data, 0);
   endtask

   initial begin
      int c, snap, d0;
      bit bad_en, bad_sr, bad_md, busy_seen;

      rst = 1; start = 0; frame_len = 0; m_ready = 0;
      step(3);
      rst = 0;
      @(negedge clk);
      check_reset_values("rst");

      // A: basic frame 1..4
      step(1);
      clr(); m_ready = 1; src_en = 1;
      push(1); push(2); push(3); push(4);
      d0 = n_done;
      start_frame(4);
      wait_done("A", 200);
      step(3);
      chk_out("A");
      chk("A_strobes", n_strb, 6);
      if (strb_q.size() == 6) begin
         for (int i = 0; i < 4; i++) chk($sformatf("A_xin%0d", i), strb_q[i], i + 1);
         chk("A_xin4", strb_q[4], 0);
         chk("A_xin5", strb_q[5], 0);
      end
      chk("A_done_pulses", n_done - d0, 1);

      // B: output backpressure
      clr(); m_ready = 0;
      push(1); push(2); push(3); push(4);
      start_frame(4);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (m_valid !== 1'b1 && c < 100);
      chk("B_first_valid", m_valid, 1);
      bad_en = 0; bad_sr = 0; bad_md = 0;
      repeat (20) begin
         @(negedge clk);
         bad_en |= f_clk_en;
         bad_sr |= s_ready;
         bad_md |= (m_data !== 16'd1) || (m_valid !== 1'b1);
      end
      chk("B_no_strobe", bad_en, 0);
      chk("B_no_sready", bad_sr, 0);
      chk("B_data_held", bad_md, 0);
      step(1);
      m_ready = 1;
      wait_done("B", 200);
      chk_out("B");

      // C: input gap mid-frame
      step(1);
      clr();
      push(5); push(6);
      start_frame(4);
      c = 0;
      while (src_q.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("C_first_two_taken", src_q.size(), 0);
      step(8);
      snap = out_q.size();
      bad_en = 0;
      repeat (10) begin
         @(negedge clk);
         bad_en |= f_clk_en;
      end
      chk("C_gap_no_strobe", bad_en, 0);
      chk("C_gap_no_output", out_q.size(), snap);
      step(1);
      push(7); push(8);
      wait_done("C", 200);
      chk_out("C");
      chk("C_strobes", n_strb, 6);

      // D: zero-length start ignored
      step(1);
      clr();
      start_frame(0);
      busy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         busy_seen |= busy;
      end
      chk("D_busy", busy_seen, 0);
      chk("D_strobes", n_strb, 0);

      // E: start while busy ignored
      step(1);
      clr();
      push(10); push(11); push(12);
      start_frame(3);
      step(2);
      start_frame(9);
      wait_done("E", 200);
      chk_out("E");
      chk("E_strobes", n_strb, 5);

      // F: reset mid-frame, then a fresh frame
      step(1);
      clr();
      push(1); push(2); push(3);
      start_frame(4);
      c = 0;
      while (src_q.size() > 1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("F_two_taken", src_q.size(), 1);
      step(1);
      rst = 1;
      step(1);
      rst = 0;
      src_en = 0;
      src_q.delete();
      @(negedge clk);
      check_reset_values("F_abort");
      step(1);
      clr();
      src_en = 1;
      push(7); push(8); push(9);
      start_frame(3);
      wait_done("F", 200);
      step(3);
      chk_out("F");

      // G: max-length frame of random data
      clr();
      for (int i = 0; i < 4095; i++) push(16'($urandom_range(0, 65535)));
      start_frame(12'd4095);
      wait_done("G", 20000);
      step(3);
      chk_out("G");
      chk("G_strobes", n_strb, 4097);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
